// File: rtl/utm_tape_controller_if.sv
// Step exchange between the tape controller and the UTM transition block.
// The controller presents {state, sym, 2'b00}; the transition block answers {next_state, new_sym, move}.
interface utm_tape_controller_if;
    logic [7:0] xfer_out;
    logic [7:0] xfer_in;

    modport master (output xfer_out, input xfer_in);
    modport slave  (input xfer_out, output xfer_in);
endinterface

// File: rtl/utm_tape_controller.sv
// Tape, head and state owner for the UTM: issues one transition request per step,
// applies the answer, and stops on halt, tape-edge fault or step limit.
module utm_tape_controller #(
    parameter int          DEPTH      = 16,
    parameter int          AW         = 4,
    parameter int          LATENCY    = 0,
    parameter logic [2:0]  HALT_STATE = 3'd7,
    parameter logic [15:0] MAX_STEPS  = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            init_state,
    input  logic [AW-1:0]         init_head,
    input  logic                  load_we,
    input  logic [AW-1:0]         load_addr,
    input  logic [2:0]            load_sym,
    input  logic [AW-1:0]         rd_addr,
    output logic [2:0]            rd_sym,
    utm_tape_controller_if.master xfer,
    output logic [2:0]            state,
    output logic [AW-1:0]         head,
    output logic [15:0]           steps,
    output logic                  busy,
    output logic                  halted,
    output logic                  fault
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, APPLY, DONE} fsm_t;

    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((LATENCY > 0) ? LATENCY - 1 : 0);

    fsm_t            fsm_q, fsm_d;
    logic [2:0]      state_q, state_d;
    logic [AW-1:0]   head_q, head_d;
    logic [15:0]     steps_q, steps_d;
    logic [7:0]      xfer_q, xfer_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;

    logic [2:0]      tape [DEPTH];
    logic            tape_we;
    logic [AW-1:0]   tape_waddr;
    logic [2:0]      tape_wdata;

    logic [2:0]      nxt_state;
    logic [2:0]      new_sym;
    logic [1:0]      move;
    logic [15:0]     steps_inc;
    logic            halt_hit;
    logic            edge_hit;
    logic [AW-1:0]   head_mv;

    assign nxt_state = xfer.xfer_in[7:5];
    assign new_sym   = xfer.xfer_in[4:2];
    assign move      = xfer.xfer_in[1:0];
    assign steps_inc = steps_q + 16'd1;
    assign halt_hit  = (nxt_state == HALT_STATE) || (move == 2'b11);

    // Head never wraps: a move off either end is reported as an edge hit and the head holds.
    always_comb begin
        head_mv  = head_q;
        edge_hit = 1'b0;
        case (move)
            2'b01: begin
                if (head_q == '0) edge_hit = 1'b1;
                else              head_mv  = head_q - 1'b1;
            end
            2'b10: begin
                if (head_q == AW'(DEPTH - 1)) edge_hit = 1'b1;
                else                          head_mv  = head_q + 1'b1;
            end
            default: head_mv = head_q;
        endcase
    end

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        head_d     = head_q;
        steps_d    = steps_q;
        xfer_d     = xfer_q;
        busy_d     = busy_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        wcnt_d     = wcnt_q;
        tape_we    = load_we && !busy_q;
        tape_waddr = load_addr;
        tape_wdata = load_sym;

        case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = init_state;
                    head_d   = init_head;
                    steps_d  = '0;
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                    if (init_state == HALT_STATE) begin
                        halted_d = 1'b1;
                        busy_d   = 1'b0;
                        fsm_d    = DONE;
                    end else begin
                        busy_d   = 1'b1;
                        fsm_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                xfer_d = {state_q, tape[head_q], 2'b00};
                wcnt_d = '0;
                fsm_d  = (LATENCY > 0) ? WAIT : APPLY;
            end
            WAIT: begin
                if (wcnt_q == WAIT_LAST) fsm_d  = APPLY;
                else                     wcnt_d = WW'(wcnt_q + 1'b1);
            end
            APPLY: begin
                tape_we    = 1'b1;
                tape_waddr = head_q;
                tape_wdata = new_sym;
                state_d    = nxt_state;
                steps_d    = steps_inc;
                head_d     = head_mv;
                fsm_d      = ISSUE;
                // Halt outranks both the edge fault and the step limit.
                if (halt_hit) begin
                    halted_d = 1'b1;
                    busy_d   = 1'b0;
                    fsm_d    = DONE;
                end else if (edge_hit || (steps_inc == MAX_STEPS)) begin
                    fault_d  = 1'b1;
                    busy_d   = 1'b0;
                    fsm_d    = DONE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            head_q   <= '0;
            steps_q  <= '0;
            xfer_q   <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            head_q   <= head_d;
            steps_q  <= steps_d;
            xfer_q   <= xfer_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Tape survives reset; reset only blocks writes in its own cycle.
    always_ff @(posedge clk) begin
        if (!reset && tape_we) tape[tape_waddr] <= tape_wdata;
    end

    assign rd_sym        = tape[rd_addr];
    assign xfer.xfer_out = xfer_q;
    assign state         = state_q;
    assign head          = head_q;
    assign steps         = steps_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_utm_tape_controller.sv
// Directed bench for utm_tape_controller: default, LATENCY=2 and MAX_STEPS=5 instances
// share host inputs and the transition response; each check targets one instance.
module tb_utm_tape_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  init_state = '0;
    logic [3:0]  init_head = '0;
    logic        load_we = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [2:0]  load_sym = '0;
    logic [3:0]  rd_addr = '0;
    logic [7:0]  resp = '0;

    logic [2:0]  rd_sym_a [3];
    logic [2:0]  state_a  [3];
    logic [3:0]  head_a   [3];
    logic [15:0] steps_a  [3];
    logic        busy_a   [3];
    logic        halted_a [3];
    logic        fault_a  [3];

    int checks = 0;
    int failures = 0;

    utm_tape_controller_if x0 ();
    utm_tape_controller_if x1 ();
    utm_tape_controller_if x2 ();
    assign x0.xfer_in = resp;
    assign x1.xfer_in = resp;
    assign x2.xfer_in = resp;

    utm_tape_controller dut0 (
        .clk(clk), .reset(reset), .start(start), .init_state(init_state), .init_head(init_head),
        .load_we(load_we), .load_addr(load_addr), .load_sym(load_sym), .rd_addr(rd_addr),
        .rd_sym(rd_sym_a[0]), .xfer(x0), .state(state_a[0]), .head(head_a[0]), .steps(steps_a[0]),
        .busy(busy_a[0]), .halted(halted_a[0]), .fault(fault_a[0]));

    utm_tape_controller #(.LATENCY(2)) dut1 (
        .clk(clk), .reset(reset), .start(start), .init_state(init_state), .init_head(init_head),
        .load_we(load_we), .load_addr(load_addr), .load_sym(load_sym), .rd_addr(rd_addr),
        .rd_sym(rd_sym_a[1]), .xfer(x1), .state(state_a[1]), .head(head_a[1]), .steps(steps_a[1]),
        .busy(busy_a[1]), .halted(halted_a[1]), .fault(fault_a[1]));

    utm_tape_controller #(.MAX_STEPS(16'd5)) dut2 (
        .clk(clk), .reset(reset), .start(start), .init_state(init_state), .init_head(init_head),
        .load_we(load_we), .load_addr(load_addr), .load_sym(load_sym), .rd_addr(rd_addr),
        .rd_sym(rd_sym_a[2]), .xfer(x2), .state(state_a[2]), .head(head_a[2]), .steps(steps_a[2]),
        .busy(busy_a[2]), .halted(halted_a[2]), .fault(fault_a[2]));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sym;
        logic [2:0]  st;
        logic [3:0]  hd;
        logic [7:0]  rsp;
        logic [7:0]  exp_xfer;
        logic [2:0]  exp_state;
        logic [3:0]  exp_head;
        logic [2:0]  exp_sym;
        logic [15:0] exp_steps;
        logic        exp_busy;
        logic        exp_halted;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        start   = 1'b0;
        load_we = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
    endtask

    // One idle cycle carrying an optional host write together with start.
    task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [2:0] sym,
                                 input logic [2:0] st, input logic [3:0] hd);
        load_we    = we;
        load_addr  = addr;
        load_sym   = sym;
        init_state = st;
        init_head  = hd;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        load_we    = 1'b0;
    endtask

    task automatic loadCell(input logic [3:0] addr, input logic [2:0] sym);
        load_we   = 1'b1;
        load_addr = addr;
        load_sym  = sym;
        tick();
        load_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int chg [3];
        int nchg;
        logic [15:0] prev;

        vecs[0] = '{3'd2, 3'd1, 4'd5,  8'b011_100_10, 8'b001_010_00, 3'd3, 4'd6,  3'd4, 16'd1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{3'd0, 3'd2, 4'd0,  8'b010_101_01, 8'b010_000_00, 3'd2, 4'd0,  3'd5, 16'd1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{3'd3, 3'd0, 4'd15, 8'b001_110_10, 8'b000_011_00, 3'd1, 4'd15, 3'd6, 16'd1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3'd1, 3'd4, 4'd8,  8'b101_111_11, 8'b100_001_00, 3'd5, 4'd8,  3'd7, 16'd1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{3'd6, 3'd3, 4'd10, 8'b111_010_00, 8'b011_110_00, 3'd7, 4'd10, 3'd2, 16'd1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{3'd5, 3'd6, 4'd9,  8'b110_000_01, 8'b110_101_00, 3'd6, 4'd8,  3'd0, 16'd1, 1'b1, 1'b0, 1'b0};

        doReset();
        checkOutput("rst_state", 16'(state_a[0]), 16'd0);
        checkOutput("rst_head", 16'(head_a[0]), 16'd0);
        checkOutput("rst_steps", steps_a[0], 16'd0);
        checkOutput("rst_xfer", 16'(x0.xfer_out), 16'd0);
        checkOutput("rst_flags", 16'({busy_a[0], halted_a[0], fault_a[0]}), 16'd0);

        // Single-step vectors; the tape load and start share one idle cycle.
        for (int i = 0; i < 6; i++) begin
            doReset();
            resp    = vecs[i].rsp;
            rd_addr = vecs[i].hd;
            applyStimulus(1'b1, vecs[i].hd, vecs[i].sym, vecs[i].st, vecs[i].hd);
            tick();
            checkOutput($sformatf("v%0d_xfer", i), 16'(x0.xfer_out), 16'(vecs[i].exp_xfer));
            tick();
            checkOutput($sformatf("v%0d_state", i), 16'(state_a[0]), 16'(vecs[i].exp_state));
            checkOutput($sformatf("v%0d_head", i), 16'(head_a[0]), 16'(vecs[i].exp_head));
            checkOutput($sformatf("v%0d_tape", i), 16'(rd_sym_a[0]), 16'(vecs[i].exp_sym));
            checkOutput($sformatf("v%0d_steps", i), steps_a[0], vecs[i].exp_steps);
            checkOutput($sformatf("v%0d_busy", i), 16'(busy_a[0]), 16'(vecs[i].exp_busy));
            checkOutput($sformatf("v%0d_halted", i), 16'(halted_a[0]), 16'(vecs[i].exp_halted));
            checkOutput($sformatf("v%0d_fault", i), 16'(fault_a[0]), 16'(vecs[i].exp_fault));
        end

        // Reset in the third cycle of a run: registers clear, tape keeps the step-1 write.
        doReset();
        for (int a = 0; a < 16; a++) loadCell(4'(a), 3'd0);
        resp    = 8'b001_011_10;
        rd_addr = 4'd4;
        applyStimulus(1'b0, 4'd0, 3'd0, 3'd0, 4'd4);
        tick();
        tick();
        checkOutput("mid_pre_head", 16'(head_a[0]), 16'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_state", 16'(state_a[0]), 16'd0);
        checkOutput("mid_head", 16'(head_a[0]), 16'd0);
        checkOutput("mid_steps", steps_a[0], 16'd0);
        checkOutput("mid_busy", 16'(busy_a[0]), 16'd0);
        checkOutput("mid_xfer", 16'(x0.xfer_out), 16'd0);
        checkOutput("mid_tape4", 16'(rd_sym_a[0]), 16'd3);

        // Halt by state on step 3.
        doReset();
        loadCell(4'd2, 3'd0);
        loadCell(4'd3, 3'd0);
        loadCell(4'd4, 3'd0);
        resp = 8'b011_001_10;
        applyStimulus(1'b0, 4'd0, 3'd0, 3'd1, 4'd2);
        for (int c = 0; c < 30 && busy_a[0]; c++) begin
            resp = (steps_a[0] == 16'd2) ? 8'b111_101_00 : 8'b011_001_10;
            tick();
        end
        checkOutput("hs_busy", 16'(busy_a[0]), 16'd0);
        checkOutput("hs_halted", 16'(halted_a[0]), 16'd1);
        checkOutput("hs_fault", 16'(fault_a[0]), 16'd0);
        checkOutput("hs_steps", steps_a[0], 16'd3);
        checkOutput("hs_state", 16'(state_a[0]), 16'd7);
        checkOutput("hs_head", 16'(head_a[0]), 16'd4);
        rd_addr = 4'd4; #1;
        checkOutput("hs_tape4", 16'(rd_sym_a[0]), 16'd5);
        rd_addr = 4'd2; #1;
        checkOutput("hs_tape2", 16'(rd_sym_a[0]), 16'd1);

        // LATENCY=2 instance: steps complete every 4 cycles.
        doReset();
        resp = 8'b010_001_00;
        applyStimulus(1'b1, 4'd3, 3'd4, 3'd2, 4'd3);
        for (int k = 0; k < 3; k++) chg[k] = 0;
        nchg = 0;
        prev = steps_a[1];
        for (int c = 1; c <= 40 && nchg < 3; c++) begin
            tick();
            if (c == 1) checkOutput("lat_xfer_first", 16'(x1.xfer_out), 16'h50);
            if (steps_a[1] != prev) begin
                chg[nchg] = c;
                nchg++;
                prev = steps_a[1];
            end
        end
        checkOutput("lat_nsteps", 16'(nchg), 16'd3);
        checkOutput("lat_first_step", 16'(chg[0]), 16'd4);
        checkOutput("lat_gap1", 16'(chg[1] - chg[0]), 16'd4);
        checkOutput("lat_gap2", 16'(chg[2] - chg[1]), 16'd4);

        // MAX_STEPS=5 instance with ignored host write and ignored start while busy.
        doReset();
        resp    = 8'b000_010_00;
        rd_addr = 4'd0;
        applyStimulus(1'b1, 4'd0, 3'd3, 3'd1, 4'd6);
        tick();
        tick();
        load_we    = 1'b1;
        load_addr  = 4'd0;
        load_sym   = 3'd7;
        init_state = 3'd4;
        init_head  = 4'd12;
        start      = 1'b1;
        tick();
        load_we    = 1'b0;
        start      = 1'b0;
        for (int c = 0; c < 40 && busy_a[2]; c++) tick();
        checkOutput("lim_busy", 16'(busy_a[2]), 16'd0);
        checkOutput("lim_fault", 16'(fault_a[2]), 16'd1);
        checkOutput("lim_halted", 16'(halted_a[2]), 16'd0);
        checkOutput("lim_steps", steps_a[2], 16'd5);
        checkOutput("lim_head", 16'(head_a[2]), 16'd6);
        checkOutput("lim_tape0", 16'(rd_sym_a[2]), 16'd3);
        applyStimulus(1'b0, 4'd0, 3'd0, 3'd2, 4'd1);
        checkOutput("restart_steps", steps_a[2], 16'd0);
        checkOutput("restart_busy", 16'(busy_a[2]), 16'd1);
        checkOutput("restart_fault", 16'(fault_a[2]), 16'd0);
        checkOutput("restart_state", 16'(state_a[2]), 16'd2);

        // Start directly in HALT_STATE.
        doReset();
        applyStimulus(1'b0, 4'd0, 3'd0, 3'd7, 4'd3);
        checkOutput("hinit_halted", 16'(halted_a[0]), 16'd1);
        checkOutput("hinit_busy", 16'(busy_a[0]), 16'd0);
        checkOutput("hinit_steps", steps_a[0], 16'd0);
        checkOutput("hinit_head", 16'(head_a[0]), 16'd3);
        tick();
        checkOutput("hinit_stay", 16'({busy_a[0], halted_a[0]}), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/utm_tape_controller.md
Name: utm_tape_controller

Overview:
- Sequential "other end" of the UTM transition block. It owns the tape, the head pointer and the encoded machine state.
- Each step it presents {state[2:0], symbol_under_head[2:0], 2'b00} on xfer_out, which wires to the transition block's io_in.
- It then samples the transition block's io_out on xfer_in as {next_state[2:0], new_sym[2:0], move[1:0]}.
- It writes the new symbol, updates the state, moves the head, and repeats until halt, fault or step limit.

Parameters:
- DEPTH, 16, number of tape cells (power of two).
- AW, 4, head/address width; DEPTH = 2**AW.
- LATENCY, 0, extra cycles to wait between driving xfer_out and sampling xfer_in.
- HALT_STATE, 3'd7, encoded state that stops the machine.
- MAX_STEPS, 16'hFFFF, step count at which the run is aborted.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse: begin run from IDLE/DONE
- init_state  input  3  state loaded at start
- init_head  input  AW  head position loaded at start
- load_we  input  1  host tape write, honoured only when busy=0
- load_addr  input  AW  host tape write address
- load_sym  input  3  host tape write data
- rd_addr  input  AW  host readback address
- rd_sym  output  3  combinational tape[rd_addr]
- xfer_out  output  8  registered {state, sym, 2'b00} to transition block
- xfer_in  input  8  {next_state, new_sym, move} from transition block
- state  output  3  current encoded state
- head  output  AW  current head position
- steps  output  16  completed step count
- busy  output  1  run in progress
- halted  output  1  run ended by HALT_STATE or move=11
- fault  output  1  head left tape or MAX_STEPS reached

Behaviour:
- Reset: FSM=IDLE, state=0, head=0, steps=0, xfer_out=0, busy=halted=fault=0. Tape contents are not cleared. reset overrides everything in that cycle, including mid-run.
- FSM states are IDLE, ISSUE, WAIT, APPLY, DONE.
- IDLE/DONE, start=1:
  - state<=init_state, head<=init_head, steps<=0, halted<=0, fault<=0.
  - busy<=1, go to ISSUE.
  - If init_state==HALT_STATE: go directly to DONE with halted=1, busy=0, steps=0.
- ISSUE: xfer_out<={state, tape[head], 2'b00}. Go to WAIT if LATENCY>0, else APPLY.
- WAIT: hold xfer_out for LATENCY cycles, then go to APPLY.
- APPLY: sample xfer_in once.
  - tape[head]<=new_sym, state<=next_state, steps<=steps+1.
  - move: 00 stay; 01 head-1; 10 head+1; 11 halt after the write.
- Halt condition (checked in APPLY): next_state==HALT_STATE or move==11. Then halted<=1, busy<=0, go to DONE; head is unchanged on move=11.
- Boundary:
  - move=01 at head=0, or move=10 at head=DEPTH-1: the write still happens, head is held, fault<=1, busy<=0, DONE. No wrap-around.
  - Step limit: if steps+1==MAX_STEPS and no halt, then fault<=1, busy<=0, DONE. If halt and limit coincide, halted=1 and fault=0; halt has priority.
- Step timing: one step = LATENCY+2 cycles, ISSUE to the next ISSUE.
- Host access:
  - load_we while busy=1 is ignored.
  - start while busy=1 is ignored.
  - load_we and start in the same idle cycle: the write takes effect and start is accepted; the first ISSUE reads the new value.
- rd_sym is combinational from tape and is valid in any state.
- xfer_out holds its last value in DONE/IDLE.

Test Plan:
- Reset mid-run: start with tape all 0, reset on the 3rd cycle of the run -> next cycle state=0, head=0, steps=0, busy=0, xfer_out=8'h00; tape[head] keeps its last written value.
- Single step, LATENCY=0:
  - Setup: load tape[5]=3'd2, init_state=1, init_head=5, start. Bench drives xfer_in=8'b011_100_10.
  - Cycle after start: xfer_out=8'b001_010_00.
  - Following cycle: state=3, tape[5]=4, head=6, steps=1.
- Halt by state: xfer_in next_state=7, move=00 on step 3 -> halted=1, busy=0, steps=3, tape updated, head unchanged.
- Left edge fault: init_head=0, xfer_in move=01, new_sym=5 -> tape[0]=5, head=0, fault=1, halted=0, steps=1.
- Right edge and timing: init_head=15, move=10 -> fault=1, head=15. Also with LATENCY=2 and a constant move=00 non-halting response, successive ISSUE cycles are exactly 4 cycles apart.
- Step limit and ignored host access: MAX_STEPS=5, non-halting move=00 -> fault=1, steps=5, busy=0. load_we=1 to addr 0 during the run leaves tape[0] unchanged. A second start during busy is ignored, and a start in DONE restarts with steps=0.
